// File: rtl/vga_fb_arbiter_if.sv
// Bundles the line-fetch, scanout, CPU and physical memory buses of vga_fb_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              line_req;
    logic [ADDR_W-1:0] line_addr;
    logic              line_busy;
    logic              line_done;
    logic              line_ovf;
    logic              scan_valid;
    logic [DATA_W-1:0] scan_data;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              phy_req;
    logic              phy_we;
    logic [ADDR_W-1:0] phy_addr;
    logic [DATA_W-1:0] phy_data;
    logic [DATA_W-1:0] phy_rdata;
    logic              phy_ack;

    modport slave (
        input  line_req, line_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, phy_rdata, phy_ack,
        output line_busy, line_done, line_ovf, scan_valid, scan_data, cpu_ack, cpu_rdata,
               phy_req, phy_we, phy_addr, phy_data
    );

    modport master (
        output line_req, line_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, phy_rdata, phy_ack,
        input  line_busy, line_done, line_ovf, scan_valid, scan_data, cpu_ack, cpu_rdata,
               phy_req, phy_we, phy_addr, phy_data
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares the framebuffer memory bus between line-burst scanout and single-word CPU accesses,
// scanout first, with a starvation limit that forces a CPU grant; one transaction in flight.
module vga_fb_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LINE_WORDS   = 160,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              rst,
    vga_fb_arbiter_if.slave  bus
);
    localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(LINE_WORDS - 1);
    localparam logic [STV_W-1:0]  STV_LIM   = STV_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(DATA_W / 8);

    typedef enum logic {S_IDLE, S_BUSY} state_e;
    typedef enum logic [1:0] {G_NONE = 2'd0, G_SCAN = 2'd1, G_CPU = 2'd2} grant_e;

    state_e            state_q, state_d;
    grant_e            grant_q, grant_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [STV_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              line_busy_q, line_busy_d;
    logic              line_done_q, line_done_d;
    logic              line_ovf_q, line_ovf_d;
    logic              scan_valid_q, scan_valid_d;
    logic [DATA_W-1:0] scan_data_q, scan_data_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              phy_req_q, phy_req_d;
    logic              phy_we_q, phy_we_d;
    logic [ADDR_W-1:0] phy_addr_q, phy_addr_d;
    logic [DATA_W-1:0] phy_data_q, phy_data_d;

    logic [ADDR_W-1:0] scan_addr;
    logic              scan_pend;

    // Address arithmetic wraps naturally at 2^ADDR_W.
    assign scan_addr = base_q + ADDR_W'(word_cnt_q) * STRIDE;
    assign scan_pend = line_busy_q;

    always_comb begin
        // NOTE: every _d starts from its _q (or 0 for pulses) so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        base_d       = base_q;
        word_cnt_d   = word_cnt_q;
        starve_cnt_d = starve_cnt_q;
        line_busy_d  = line_busy_q;
        line_done_d  = 1'b0;
        line_ovf_d   = 1'b0;
        scan_valid_d = 1'b0;
        scan_data_d  = scan_data_q;
        cpu_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        phy_req_d    = phy_req_q;
        phy_we_d     = phy_we_q;
        phy_addr_d   = phy_addr_q;
        phy_data_d   = phy_data_q;

        // Line acceptance runs beside the FSM; a busy line can never also be re-accepted.
        if (bus.line_req) begin
            if (line_busy_q) begin
                line_ovf_d = 1'b1;
            end else begin
                base_d      = bus.line_addr;
                word_cnt_d  = '0;
                line_busy_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (scan_pend && (!bus.cpu_req || starve_cnt_q < STV_LIM)) begin
                    state_d      = S_BUSY;
                    grant_d      = G_SCAN;
                    phy_req_d    = 1'b1;
                    phy_we_d     = 1'b0;
                    phy_addr_d   = scan_addr;
                    starve_cnt_d = bus.cpu_req ? starve_cnt_q + STV_W'(1) : '0;
                end else if (bus.cpu_req) begin
                    state_d      = S_BUSY;
                    grant_d      = G_CPU;
                    phy_req_d    = 1'b1;
                    phy_we_d     = bus.cpu_we;
                    phy_addr_d   = bus.cpu_addr;
                    phy_data_d   = bus.cpu_wdata;
                    starve_cnt_d = '0;
                end
            end
            S_BUSY: begin
                if (bus.phy_ack) begin
                    state_d   = S_IDLE;
                    grant_d   = G_NONE;
                    phy_req_d = 1'b0;
                    if (grant_q == G_SCAN) begin
                        scan_valid_d = 1'b1;
                        scan_data_d  = bus.phy_rdata;
                        if (word_cnt_q == LAST_WORD) begin
                            line_done_d = 1'b1;
                            line_busy_d = 1'b0;
                            word_cnt_d  = '0;
                        end else begin
                            word_cnt_d = word_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!phy_we_q) cpu_rdata_d = bus.phy_rdata;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= G_NONE;
            base_q       <= '0;
            word_cnt_q   <= '0;
            starve_cnt_q <= '0;
            line_busy_q  <= 1'b0;
            line_done_q  <= 1'b0;
            line_ovf_q   <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_data_q  <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            phy_req_q    <= 1'b0;
            phy_we_q     <= 1'b0;
            phy_addr_q   <= '0;
            phy_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            base_q       <= base_d;
            word_cnt_q   <= word_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            line_busy_q  <= line_busy_d;
            line_done_q  <= line_done_d;
            line_ovf_q   <= line_ovf_d;
            scan_valid_q <= scan_valid_d;
            scan_data_q  <= scan_data_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            phy_req_q    <= phy_req_d;
            phy_we_q     <= phy_we_d;
            phy_addr_q   <= phy_addr_d;
            phy_data_q   <= phy_data_d;
        end
    end

    assign bus.line_busy  = line_busy_q;
    assign bus.line_done  = line_done_q;
    assign bus.line_ovf   = line_ovf_q;
    assign bus.scan_valid = scan_valid_q;
    assign bus.scan_data  = scan_data_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.phy_req    = phy_req_q;
    assign bus.phy_we     = phy_we_q;
    assign bus.phy_addr   = phy_addr_q;
    assign bus.phy_data   = phy_data_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter (LINE_WORDS=4, STARVE_LIMIT=2) with a delay-programmable
// memory responder that logs every completed physical transaction.
module tb_vga_fb_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(4), .STARVE_LIMIT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int            ack_delay = 0;
    int            wait_cnt  = 0;
    logic [DW-1:0] mem [logic [AW-1:0]];
    txn_t          log_q[$];
    logic          hold_valid = 1'b0;
    txn_t          hold;
    int            stab_err = 0;

    logic [DW-1:0] scan_q[$];
    int            done_idx_q[$];
    int            ovf_cnt  = 0;
    int            lat_err  = 0;
    int            done_err = 0;

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: acks after ack_delay extra cycles and checks the request is held stable.
    always @(negedge clk) begin
        if (!rst) begin
            bus.phy_ack = 1'b0;
            wait_cnt    = 0;
            hold_valid  = 1'b0;
        end else if (bus.phy_ack) begin
            bus.phy_ack = 1'b0;
            hold_valid  = 1'b0;
        end else if (bus.phy_req) begin
            if (hold_valid && (hold.addr !== bus.phy_addr || hold.we !== bus.phy_we ||
                               hold.data !== bus.phy_data))
                stab_err++;
            hold_valid = 1'b1;
            hold.addr  = bus.phy_addr;
            hold.we    = bus.phy_we;
            hold.data  = bus.phy_data;
            if (wait_cnt >= ack_delay) begin
                bus.phy_rdata = mem_read(bus.phy_addr);
                if (bus.phy_we) mem[bus.phy_addr] = bus.phy_data;
                log_q.push_back(hold);
                bus.phy_ack = 1'b1;
                wait_cnt    = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Output monitor: completions must appear exactly one cycle after the sampled phy_ack.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            if ((bus.scan_valid | bus.cpu_ack) !== bus.phy_ack) lat_err++;
            if (bus.scan_valid) scan_q.push_back(bus.scan_data);
            if (bus.line_done) begin
                if (!bus.scan_valid) done_err++;
                done_idx_q.push_back(scan_q.size());
            end
            if (bus.line_ovf) ovf_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion, required completion before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        log_q.delete();
        scan_q.delete();
        done_idx_q.delete();
        ovf_cnt = 0;
    endtask

    task automatic issue_line(input logic [AW-1:0] addr);
        @(negedge clk);
        bus.line_req  = 1'b1;
        bus.line_addr = addr;
        @(negedge clk);
        bus.line_req  = 1'b0;
    endtask

    task automatic wait_line_done(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_idx_q.size() > 0) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, 64'(got), 64'd1);
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input string tag, output logic [DW-1:0] rdata);
        bit got = 1'b0;
        rdata         = '0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin
                rdata = bus.cpu_rdata;
                got   = 1'b1;
                break;
            end
        end
        bus.cpu_req = 1'b0;
        check(tag, 64'(got), 64'd1);
    endtask

    task automatic check_addrs(input string tag, input logic [AW-1:0] exp_q[$]);
        check({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), 64'(log_q[i].addr), 64'(exp_q[i]));
    endtask

    logic [AW-1:0] exp_q[$];
    logic [DW-1:0] rd;
    int            n2000;
    bit            seen;
    logic          any_req;

    initial begin
        bus.line_req  = 1'b0;
        bus.line_addr = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.phy_rdata = '0;
        bus.phy_ack   = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_flags", 64'({bus.phy_req, bus.phy_we, bus.line_busy, bus.line_done,
                                bus.line_ovf, bus.scan_valid, bus.cpu_ack}), 64'd0);
        check("rst_phy_addr", 64'(bus.phy_addr), 64'd0);
        check("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Line fetch with a 3-cycle memory delay per word.
        ack_delay = 3;
        clear_logs();
        issue_line(32'h0000_1000);
        check("line_busy_set", 64'(bus.line_busy), 64'd1);
        wait_line_done("line_done_seen");
        @(negedge clk);
        exp_q = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C};
        check_addrs("fetch", exp_q);
        check("fetch_we0", 64'(log_q[0].we), 64'd0);
        check("fetch_nvalid", 64'(scan_q.size()), 64'd4);
        check("fetch_data0", 64'(scan_q[0]), 64'h5A5A_1000);
        check("fetch_data3", 64'(scan_q[3]), 64'h5A5A_100C);
        check("fetch_done_at4", 64'(done_idx_q[0]), 64'd4);
        check("fetch_busy_clr", 64'(bus.line_busy), 64'd0);

        // CPU write then read back with zero-wait memory.
        ack_delay = 0;
        clear_logs();
        cpu_access(1'b1, 32'h20, 32'hDEAD_BEEF, "cpu_wr_ack", rd);
        check("cpu_wr_rdata_hold", 64'(rd), 64'd0);
        @(negedge clk);
        cpu_access(1'b0, 32'h20, 32'h0, "cpu_rd_ack", rd);
        check("cpu_rd_data", 64'(rd), 64'hDEAD_BEEF);
        check("cpu_nxact", 64'(log_q.size()), 64'd2);
        check("cpu_wr_we", 64'(log_q[0].we), 64'd1);
        check("cpu_wr_data", 64'(log_q[0].data), 64'hDEAD_BEEF);
        check("cpu_rd_we", 64'(log_q[1].we), 64'd0);
        check("cpu_rd_addr", 64'(log_q[1].addr), 64'h20);

        // Starvation: CPU held against a line; limit 2 gives S,S,C,S,S,C.
        @(negedge clk);
        clear_logs();
        issue_line(32'h0000_3000);
        cpu_access(1'b0, 32'h40, 32'h0, "starve_ack1", rd);
        check("starve_rd1", 64'(rd), 64'h5A5A_0040);
        @(negedge clk);
        cpu_access(1'b0, 32'h40, 32'h0, "starve_ack2", rd);
        exp_q = '{32'h3000, 32'h3004, 32'h40, 32'h3008, 32'h300C, 32'h40};
        check_addrs("starve", exp_q);
        check("starve_ndone", 64'(done_idx_q.size()), 64'd1);
        check("starve_done_at4", 64'(done_idx_q[0]), 64'd4);

        // Overflow: a second line request during an active line is dropped.
        ack_delay = 3;
        @(negedge clk);
        clear_logs();
        issue_line(32'h0000_1000);
        repeat (2) @(negedge clk);
        issue_line(32'h0000_2000);
        wait_line_done("ovf_line_done");
        repeat (3) @(negedge clk);
        check("ovf_pulses", 64'(ovf_cnt), 64'd1);
        n2000 = 0;
        foreach (log_q[i]) if (log_q[i].addr[31:12] == 20'h2) n2000++;
        check("ovf_no_2000", 64'(n2000), 64'd0);
        exp_q = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C};
        check_addrs("ovf", exp_q);

        // Address wrap across 2^32.
        ack_delay = 0;
        clear_logs();
        issue_line(32'hFFFF_FFF8);
        wait_line_done("wrap_done");
        exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        check_addrs("wrap", exp_q);

        // Asynchronous reset in the middle of word 2.
        ack_delay = 3;
        @(negedge clk);
        clear_logs();
        issue_line(32'h0000_1000);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.phy_req && bus.phy_addr == 32'h0000_1008) begin
                seen = 1'b1;
                break;
            end
        end
        check("midrst_word2", 64'(seen), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_flags", 64'({bus.phy_req, bus.phy_we, bus.line_busy, bus.line_done,
                                   bus.line_ovf, bus.scan_valid, bus.cpu_ack}), 64'd0);
        check("midrst_phy_addr", 64'(bus.phy_addr), 64'd0);
        check("midrst_scan_data", 64'(bus.scan_data), 64'd0);
        check("midrst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        any_req = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_req = any_req | bus.phy_req | bus.line_busy;
        end
        check("postrst_idle", 64'(any_req), 64'd0);

        check("phy_stable", 64'(stab_err), 64'd0);
        check("ack_latency", 64'(lat_err), 64'd0);
        check("done_with_valid", 64'(done_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
